// File: rtl/esc_pkg.sv
// esc_pkg: shared ESC direction encodings, speed-meter FSM states and Gray-step helper
package esc_pkg;
  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_REV  = 2'b01;
  localparam logic [1:0] DIR_FWD  = 2'b10;
  typedef enum logic [1:0] {IDLE, MEASURE, STALL} meas_state_t;
  function automatic logic [1:0] gray_next(input logic [1:0] g);
    return {g[0], ~g[1]};
  endfunction
endpackage

// File: rtl/quad_input_filter.sv
// quad_input_filter: 2-FF synchroniser plus FILTER_LEN stability filter for {a,b}; ports clk, reset (sync active-low), raw[1:0] in, filt[1:0] out
module quad_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s1 != s2 || s2 == filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/encoder_speed_meter.sv
// encoder_speed_meter: quadrature decode (position, direction, illegal flag) and A-edge period/stall measurement; ports clk, reset (sync active-low), encoder_a/b raw in, speed_period, speed_valid, direction, position, stalled, err_illegal out
module encoder_speed_meter
  import esc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FILTER_LEN = 3,
  parameter int POS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  encoder_a,
  input  logic                  encoder_b,
  output logic [DATA_WIDTH-1:0] speed_period,
  output logic                  speed_valid,
  output logic [1:0]            direction,
  output logic [POS_WIDTH-1:0]  position,
  output logic                  stalled,
  output logic                  err_illegal
);
  localparam logic [DATA_WIDTH-1:0] PMAX = '1;
  logic [1:0] filt, filt_q;
  logic [DATA_WIDTH-1:0] cnt;
  meas_state_t state;
  logic chg, step_fwd, step_rev, illegal, arise;
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk  (clk),
    .reset(reset),
    .raw  ({encoder_a, encoder_b}),
    .filt (filt)
  );
  assign chg      = filt != filt_q;
  assign step_fwd = chg && filt == gray_next(filt_q);
  assign step_rev = chg && filt_q == gray_next(filt);
  assign illegal  = (filt ^ filt_q) == 2'b11;
  assign arise    = filt[1] & ~filt_q[1];
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_q <= '0;
      speed_period <= '0;
      speed_valid <= 1'b0;
      direction <= DIR_STOP;
      position <= '0;
      stalled <= 1'b0;
      err_illegal <= 1'b0;
      cnt <= '0;
      state <= IDLE;
    end else begin
      filt_q <= filt;
      speed_valid <= 1'b0;
      if (step_fwd) begin
        position <= position + 1'b1;
        direction <= DIR_FWD;
      end else if (step_rev) begin
        position <= position - 1'b1;
        direction <= DIR_REV;
      end
      if (illegal) err_illegal <= 1'b1;
      // stall handling follows the step update so a stall forces direction to stop
      case (state)
        IDLE: if (arise) begin
          state <= MEASURE;
          cnt <= DATA_WIDTH'(1);
        end
        MEASURE: if (arise) begin
          speed_period <= cnt;
          speed_valid <= 1'b1;
          cnt <= DATA_WIDTH'(1);
        end else if (cnt == PMAX) begin
          state <= STALL;
          stalled <= 1'b1;
          speed_period <= PMAX;
          speed_valid <= 1'b1;
          direction <= DIR_STOP;
        end else cnt <= cnt + 1'b1;
        STALL: if (arise) begin
          state <= MEASURE;
          stalled <= 1'b0;
          cnt <= DATA_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
